// File: rtl/rom_stream_reader.sv
// ---------------------------------------------------------------------------
// rom_stream_reader
//
// Walks a contiguous, wrapping address range of a small combinational ROM,
// registers each returned word and presents it as a ready/valid stream. The
// final beat of a burst carries out_last, a running checksum of the emitted
// words is kept, and done pulses for one cycle once the last beat has left.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   start      : command strobe, only honoured while idle
//   start_addr : first ROM address of the burst
//   count      : number of beats (0 allowed)
//   rom_addr   : registered address to the ROM
//   rom_data   : combinational ROM word for rom_addr
//   out_valid  : out_data/out_last hold a beat
//   out_ready  : downstream accepts the beat
//   out_data   : captured ROM word
//   out_last   : final beat of the burst
//   busy       : a burst is running or completing
//   done       : one-cycle completion pulse
//   checksum   : sum of words emitted in the current/last burst
// ---------------------------------------------------------------------------
module rom_stream_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4,
  parameter int SUM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic [SUM_W-1:0]  checksum_q,  checksum_d;

  logic xfer;
  logic capture;

  // Zero-extending accumulate; SUM_W is sized so the sum cannot overflow.
  function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] acc,
                                               input logic [DATA_W-1:0] word);
    return acc + SUM_W'(word);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    checksum_d  = checksum_q;

    xfer    = out_valid_q && out_ready;
    // The output slot is free when empty or being drained this edge.
    capture = (state_q == S_RUN) && (!out_valid_q || out_ready) &&
              (remaining_q != '0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = count;
          checksum_d  = '0;
          state_d     = (count != '0) ? S_RUN : S_DONE;
        end
      end

      S_RUN: begin
        if (capture) begin
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          out_last_d  = (remaining_q == CNT_W'(1));
          checksum_d  = sum_add(checksum_q, rom_data);
          addr_d      = addr_q + ADDR_W'(1);   // wraps modulo 2**ADDR_W
          remaining_d = remaining_q - CNT_W'(1);
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
        // remaining is already 0 when the last beat leaves, so no capture
        // competes with this transition.
        if (xfer && out_last_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      checksum_q  <= checksum_d;
    end
  end

  assign rom_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign checksum  = checksum_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule
